// File: rtl/obi_mem_responder.sv
// OBI data-channel responder driving a single-port SRAM with 1-cycle read latency.
// Optional macro OBI_RREADY_EN adds rready_i back-pressure and an in-order response FIFO.
module obi_mem_responder #(
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       DATA_W          = 32,
  parameter int unsigned       ID_W            = 1,
  parameter int unsigned       N_WORDS         = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = 32'h2000_0000,
  parameter int unsigned       MAX_OUTSTANDING = 2,
  localparam int unsigned      STRB_W          = DATA_W / 8,
  localparam int unsigned      MEM_AW          = $clog2(N_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [STRB_W-1:0] be_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ID_W-1:0]   aid_i,
  output logic              rvalid_o,
`ifdef OBI_RREADY_EN
  input  logic              rready_i,
`endif
  output logic [DATA_W-1:0] rdata_o,
  output logic [ID_W-1:0]   rid_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [STRB_W-1:0] mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned     CW   = $clog2(MAX_OUTSTANDING + 2);
  localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(4 * N_WORDS);

  logic [ADDR_W-1:0] off;
  logic              hit;
  logic              ready;
  logic              retire;
  logic [CW-1:0]     cnt;

  logic              s1_valid;
  logic [ID_W-1:0]   s1_aid;
  logic              s1_we;
  logic              s1_err;
  logic [DATA_W-1:0] s1_rdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic [ID_W-1:0]   resp_id;
  logic              resp_err;

  assign off = addr_i - BASE_ADDR;
  assign hit = (addr_i >= BASE_ADDR) && ({1'b0, off} < SPAN);

  // Credit check discounts a response retiring this cycle so a full pipe still streams.
  assign retire = rvalid_o & ready;
  assign gnt_o  = req_i & ~rst_i & ((cnt - CW'(retire)) < CW'(MAX_OUTSTANDING));

  assign mem_req_o   = gnt_o & hit;
  assign mem_we_o    = mem_req_o & we_i;
  assign mem_addr_o  = off[MEM_AW+1:2];
  assign mem_be_o    = be_i;
  assign mem_wdata_o = wdata_i;

  assign s1_rdata = (s1_we | s1_err) ? '0 : mem_rdata_i;

  // S1 always drains: it is either retired or moved into the FIFO every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_aid   <= '0;
      s1_we    <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= gnt_o;
      if (gnt_o) begin
        s1_aid <= aid_i;
        s1_we  <= we_i;
        s1_err <= ~hit;
      end
    end
  end

`ifdef OBI_RREADY_EN
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [DATA_W-1:0] fifo_rdata [MAX_OUTSTANDING];
  logic [ID_W-1:0]   fifo_id    [MAX_OUTSTANDING];
  logic              fifo_err   [MAX_OUTSTANDING];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready      = rready_i;
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = ~fifo_empty & ready;
  assign push       = s1_valid & (~fifo_empty | ~ready);
  assign cnt        = CW'(s1_valid) + fifo_cnt;

  always_comb begin
    resp_valid = s1_valid | ~fifo_empty;
    if (fifo_empty) begin
      resp_rdata = s1_rdata;
      resp_id    = s1_aid;
      resp_err   = s1_err;
    end else begin
      resp_rdata = fifo_rdata[rd_ptr];
      resp_id    = fifo_id[rd_ptr];
      resp_err   = fifo_err[rd_ptr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rdata[wr_ptr] <= s1_rdata;
      fifo_id[wr_ptr]    <= s1_aid;
      fifo_err[wr_ptr]   <= s1_err;
    end
  end
`else
  assign ready = 1'b1;
  assign cnt   = CW'(s1_valid);

  always_comb begin
    resp_valid = s1_valid;
    resp_rdata = s1_rdata;
    resp_id    = s1_aid;
    resp_err   = s1_err;
  end
`endif

  assign rvalid_o = resp_valid & ~rst_i;
  assign rdata_o  = rvalid_o ? resp_rdata : '0;
  assign rid_o    = rvalid_o ? resp_id    : '0;
  assign err_o    = rvalid_o & resp_err;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Self-checking bench for obi_mem_responder: SRAM environment model plus a
// transaction-level reference (byte memory image and in-order response queue).
module tb_obi_mem_responder;

  localparam int          NW   = 1024;
  localparam int          MAXO = 2;
  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk, rst, req, we, aid, rready;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt_o, rvalid_o, rid_o, err_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;

  obi_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .ID_W(1), .N_WORDS(NW),
    .BASE_ADDR(BASE), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_o),
    .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata), .aid_i(aid),
    .rvalid_o(rvalid_o),
`ifdef OBI_RREADY_EN
    .rready_i(rready),
`endif
    .rdata_o(rdata_o), .rid_o(rid_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM environment: 1-cycle read latency, garbage on the read bus otherwise.
  logic [31:0] sram [NW];
  always @(posedge clk) begin
    if (mem_req_o && mem_we_o) begin
      for (int k = 0; k < 4; k++)
        if (mem_be_o[k]) sram[mem_addr_o][8*k +: 8] <= mem_wdata_o[8*k +: 8];
      mem_rdata_i <= $urandom;
    end else if (mem_req_o) begin
      mem_rdata_i <= sram[mem_addr_o];
    end else begin
      mem_rdata_i <= $urandom;
    end
  end

  // Reference model
  typedef struct {
    logic [31:0] rdata;
    logic        rid;
    logic        err;
  } rsp_t;

  logic [31:0] ref_mem [NW];
  rsp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic bit m_hit(input logic [31:0] a);
    longint d = longint'({32'h0, a}) - longint'({32'h0, BASE});
    return (d >= 0) && (d < 4 * NW);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2) & (NW - 1);
  endfunction

  function automatic bit m_ready();
`ifdef OBI_RREADY_EN
    return rready;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit m_rvalid();
    return exp_q.size() != 0;
  endfunction

  function automatic bit m_gnt();
    int pend = exp_q.size() - ((m_rvalid() && m_ready()) ? 1 : 0);
    return req && !rst && (pend < MAXO);
  endfunction

  task automatic drive(input bit r, input logic [31:0] a, input bit w,
                       input logic [3:0] b, input logic [31:0] d, input bit id);
    req = r; addr = a; we = w; be = b; wdata = d; aid = id;
  endtask

  // Updates the reference for the current cycle's inputs, then moves to the next cycle.
  task automatic advance();
    bit   g = m_gnt();
    bit   rv = m_rvalid();
    rsp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rv && m_ready()) void'(exp_q.pop_front());
      if (g) begin
        e.rid   = aid;
        e.err   = !m_hit(addr);
        e.rdata = (m_hit(addr) && !we) ? ref_mem[m_idx(addr)] : 32'h0;
        if (m_hit(addr) && we)
          for (int k = 0; k < 4; k++)
            if (be[k]) ref_mem[m_idx(addr)][8*k +: 8] = wdata[8*k +: 8];
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, BASE, 1'b0, 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #3;
      n_cmp++; if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got=%b want=0", gnt_o); end
      n_cmp++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%b want=0", rvalid_o); end
      n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b want=0", mem_req_o); end
      n_cmp++; if ({rdata_o, rid_o, err_o} !== 34'h0) begin n_fail++; $display("FAIL reset_resp got=%h/%b/%b want=0", rdata_o, rid_o, err_o); end
      advance();
    end
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    advance();
  endtask

  task automatic test_write_read();
    logic [31:0] old = ref_mem[4];
    drive(1'b1, 32'h2000_0010, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1'b1);
    #3;
    n_cmp++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL wr_gnt got=%b want=1", gnt_o); end
    n_cmp++; if ({mem_req_o, mem_we_o} !== 2'b11) begin n_fail++; $display("FAIL wr_mem_req got=%b%b want=11", mem_req_o, mem_we_o); end
    n_cmp++; if (mem_addr_o !== 10'd4) begin n_fail++; $display("FAIL wr_mem_addr got=%0d want=4", mem_addr_o); end
    n_cmp++; if (mem_be_o !== 4'b0011) begin n_fail++; $display("FAIL wr_mem_be got=%b want=0011", mem_be_o); end
    advance();
    drive(1'b1, 32'h2000_0012, 1'b0, 4'hF, 32'h0, 1'b0);
    #3;
    n_cmp++; if ({rvalid_o, rid_o, err_o} !== 3'b110) begin n_fail++; $display("FAIL wr_resp got=%b%b%b want=110", rvalid_o, rid_o, err_o); end
    n_cmp++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL wr_rdata got=%h want=0", rdata_o); end
    n_cmp++; if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 10'd4}) begin n_fail++; $display("FAIL rd_mem got=%b%b/%0d want=10/4", mem_req_o, mem_we_o, mem_addr_o); end
    advance();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    #3;
    n_cmp++; if ({rvalid_o, rid_o, err_o} !== 3'b100) begin n_fail++; $display("FAIL rd_resp got=%b%b%b want=100", rvalid_o, rid_o, err_o); end
    n_cmp++; if (rdata_o !== {old[31:16], 16'hBEEF}) begin n_fail++; $display("FAIL rd_rdata got=%h want=%h", rdata_o, {old[31:16], 16'hBEEF}); end
    advance();
  endtask

  task automatic test_errors();
    logic [31:0] bad [2];
    bad[0] = 32'h1FFF_FFFC;
    bad[1] = 32'h2000_1000;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, bad[i], 1'b0, 4'hF, 32'h0, 1'(i ^ 1));
      #3;
      n_cmp++; if ({gnt_o, mem_req_o} !== 2'b10) begin n_fail++; $display("FAIL err_addr_phase[%0d] gnt/mem_req got=%b%b want=10", i, gnt_o, mem_req_o); end
      advance();
      drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      #3;
      n_cmp++; if ({rvalid_o, err_o, rid_o} !== {2'b11, 1'(i ^ 1)}) begin n_fail++; $display("FAIL err_resp[%0d] got=%b%b%b want=11%b", i, rvalid_o, err_o, rid_o, 1'(i ^ 1)); end
      n_cmp++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL err_rdata[%0d] got=%h want=0", i, rdata_o); end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    rready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1'b1, BASE + 32'($urandom_range(0, NW - 1) * 4), 1'b0, 4'hF, 32'h0, 1'(i & 1));
      else       drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      #3;
      if (i < 8) begin
        n_cmp++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt[%0d] got=%b want=1", i, gnt_o); end
      end
      if (i > 0) begin
        n_cmp++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid[%0d] got=%b want=1", i, rvalid_o); end
        else if ({rdata_o, rid_o, err_o} !== {exp_q[0].rdata, 1'((i - 1) & 1), 1'b0}) begin
          n_fail++; $display("FAIL b2b_resp[%0d] got=%h/%b/%b want=%h/%b/0", i, rdata_o, rid_o, err_o, exp_q[0].rdata, 1'((i - 1) & 1));
        end
      end
      advance();
    end
  endtask

  task automatic test_random(input int cycles, input bit rand_ready);
    logic [31:0] a;
    for (int i = 0; i < cycles; i++) begin
      case ($urandom_range(0, 7))
        0:       a = BASE - 32'($urandom_range(1, 16) * 4) + 32'($urandom_range(0, 3));
        1:       a = BASE + 32'(4 * NW) + 32'($urandom_range(0, 64));
        default: a = BASE + 32'($urandom_range(0, 4 * NW - 1));
      endcase
      rready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      drive(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, 1'($urandom));
      #3;
      n_cmp++; if (gnt_o !== m_gnt()) begin n_fail++; $display("FAIL rnd_gnt[%0d] got=%b want=%b", i, gnt_o, m_gnt()); end
      n_cmp++; if (mem_req_o !== (m_gnt() && m_hit(a))) begin n_fail++; $display("FAIL rnd_mem_req[%0d] got=%b want=%b", i, mem_req_o, m_gnt() && m_hit(a)); end
      if (m_gnt() && m_hit(a)) begin
        n_cmp++; if ({mem_we_o, mem_addr_o} !== {we, 10'(m_idx(a))}) begin n_fail++; $display("FAIL rnd_mem_addr[%0d] got=%b/%0d want=%b/%0d", i, mem_we_o, mem_addr_o, we, m_idx(a)); end
      end
      n_cmp++; if (rvalid_o !== m_rvalid()) begin n_fail++; $display("FAIL rnd_rvalid[%0d] got=%b want=%b", i, rvalid_o, m_rvalid()); end
      else if (m_rvalid()) begin
        n_cmp++; if ({rdata_o, rid_o, err_o} !== {exp_q[0].rdata, exp_q[0].rid, exp_q[0].err}) begin
          n_fail++; $display("FAIL rnd_resp[%0d] got=%h/%b/%b want=%h/%b/%b", i, rdata_o, rid_o, err_o, exp_q[0].rdata, exp_q[0].rid, exp_q[0].err);
        end
      end else begin
        n_cmp++; if ({rdata_o, rid_o, err_o} !== 34'h0) begin n_fail++; $display("FAIL rnd_idle_resp[%0d] got=%h/%b/%b want=0", i, rdata_o, rid_o, err_o); end
      end
      advance();
    end
    rready = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    repeat (MAXO + 1) advance();
    n_cmp++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rnd_drain got=%b want=0", rvalid_o); end
    exp_q.delete();
  endtask

`ifdef OBI_RREADY_EN
  task automatic test_rready();
    int grants = 0;
    rready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) rready = 1'b1;
      drive(i < 4 || i >= 5, BASE + 32'($urandom_range(0, NW - 1) * 4), 1'b0, 4'hF, 32'h0, 1'(i & 1));
      #3;
      if (i < 5 && gnt_o === 1'b1) grants++;
      n_cmp++; if (gnt_o !== m_gnt()) begin n_fail++; $display("FAIL rr_gnt[%0d] got=%b want=%b", i, gnt_o, m_gnt()); end
      n_cmp++; if (rvalid_o !== m_rvalid()) begin n_fail++; $display("FAIL rr_rvalid[%0d] got=%b want=%b", i, rvalid_o, m_rvalid()); end
      else if (m_rvalid() && {rdata_o, rid_o} !== {exp_q[0].rdata, exp_q[0].rid}) begin
        n_fail++; $display("FAIL rr_resp[%0d] got=%h/%b want=%h/%b", i, rdata_o, rid_o, exp_q[0].rdata, exp_q[0].rid);
      end
      advance();
    end
    n_cmp++; if (grants !== MAXO) begin n_fail++; $display("FAIL rr_grant_count got=%0d want=%0d", grants, MAXO); end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    repeat (MAXO + 1) advance();
    exp_q.delete();
  endtask
`endif

  task automatic test_reset_pending();
    rready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, BASE + 32'(8 * i), 1'b0, 4'hF, 32'h0, 1'(i));
      advance();
    end
    rst = 1'b1;
    drive(1'b1, BASE, 1'b0, 4'hF, 32'h0, 1'b0);
    #3;
    n_cmp++; if ({gnt_o, rvalid_o} !== 2'b00) begin n_fail++; $display("FAIL rstp_during got=%b%b want=00", gnt_o, rvalid_o); end
    advance();
    rst = 1'b0;
    rready = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    #3;
    n_cmp++; if ({gnt_o, rvalid_o} !== 2'b00) begin n_fail++; $display("FAIL rstp_after got=%b%b want=00", gnt_o, rvalid_o); end
    advance();
    drive(1'b1, BASE + 32'h40, 1'b0, 4'hF, 32'h0, 1'b1);
    #3;
    n_cmp++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL rstp_gnt got=%b want=1", gnt_o); end
    advance();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    #3;
    n_cmp++; if ({rvalid_o, rid_o, err_o, rdata_o} !== {3'b110, ref_mem[16]}) begin
      n_fail++; $display("FAIL rstp_resp got=%b%b%b/%h want=110/%h", rvalid_o, rid_o, err_o, rdata_o, ref_mem[16]);
    end
    advance();
    #3;
    n_cmp++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rstp_stale got=%b want=0", rvalid_o); end
    advance();
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      ref_mem[i] = $urandom;
      sram[i]    = ref_mem[i];
    end
    rst = 1'b1;
    rready = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    #1;
    test_reset();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_random(300, 1'b0);
`ifdef OBI_RREADY_EN
    test_rready();
    test_random(300, 1'b1);
`endif
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
